// File: rtl/stream_demux_pkg.sv
// Shared definitions for the registered stream demultiplexer.
// Default parameters, select-width helper and the occupancy state type.
package stream_demux_pkg;

    localparam int DMX_WIDTH = 8;
    localparam int DMX_N_OUT = 4;
    localparam int DMX_SEL_W = 2;
    localparam int DMX_CNT_W = 8;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } dmx_state_e;

    function automatic int dmx_clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; sticks at all-ones instead of wrapping.
// Reusable event counter with asynchronous active-low reset.
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/stream_demux.sv
// Registered 1-to-N stream demultiplexer with per-lane enable and broadcast.
// Holds each word until every targeted lane has taken it; unroutable words are counted.
module stream_demux
    import stream_demux_pkg::*;
#(
    parameter int WIDTH = DMX_WIDTH,
    parameter int N_OUT = DMX_N_OUT,
    parameter int SEL_W = DMX_SEL_W,
    parameter int CNT_W = DMX_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0] in_sel,
    input  logic             in_bcast,
    input  logic [N_OUT-1:0] ch_en,
    output logic [N_OUT-1:0] out_valid,
    input  logic [N_OUT-1:0] out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] drop_cnt,
    output logic             busy
);

    if (SEL_W < dmx_clog2(N_OUT)) begin : g_sel_chk
        $error("SEL_W too narrow for N_OUT");
    end

    logic [N_OUT-1:0] pend;
    logic [N_OUT-1:0] pend_nxt;
    logic [N_OUT-1:0] sel_oh;
    logic [N_OUT-1:0] mask;
    logic             accept;
    logic             drop;
    logic             load;
    dmx_state_e       state;

    // Selects beyond N_OUT match no bit and therefore decode to an empty mask.
    always_comb begin
        sel_oh = '0;
        for (int i = 0; i < N_OUT; i++) begin
            if (32'(in_sel) == i) sel_oh[i] = 1'b1;
        end
    end

    assign mask  = in_bcast ? ch_en : (sel_oh & ch_en);
    assign state = (pend == '0) ? IDLE : HOLD;

    always_comb begin
        in_ready = 1'b1;
        unique case (state)
            IDLE: in_ready = 1'b1;
            HOLD: in_ready = ((pend & ~out_ready) == '0);
            default: in_ready = 1'b1;
        endcase
    end

    assign accept = in_valid && in_ready;
    assign load   = accept && (mask != '0);
    assign drop   = accept && (mask == '0);

    // An accept implies every pending lane retires on this edge, so no bubble.
    always_comb begin
        pend_nxt = pend & ~out_ready;
        if (accept) pend_nxt = mask;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend     <= '0;
            out_data <= '0;
        end else begin
            pend <= pend_nxt;
            if (load) out_data <= in_data;
        end
    end

    assign out_valid = pend;
    assign busy      = (state == HOLD);

    sat_counter #(
        .CNT_W(CNT_W)
    ) u_drop_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .inc  (drop),
        .cnt  (drop_cnt)
    );

endmodule

// File: tb/tb_stream_demux.sv
// Scoreboard bench for stream_demux: per-lane expected-word queues fed at accept,
// drained by a negedge monitor; a second 3-lane instance covers saturation.
module tb_stream_demux;

    logic       clk = 1'b0;
    logic       rst_n;
    always #5 clk = ~clk;

    logic       in_valid, in_ready, in_bcast, busy;
    logic [7:0] in_data, out_data, drop_cnt;
    logic [1:0] in_sel;
    logic [3:0] ch_en, out_valid, out_ready;

    logic       b_in_valid, b_in_ready, b_in_bcast, b_busy;
    logic [7:0] b_in_data, b_out_data;
    logic [1:0] b_in_sel, b_drop_cnt;
    logic [2:0] b_ch_en, b_out_valid, b_out_ready;

    stream_demux #(.WIDTH(8), .N_OUT(4), .SEL_W(2), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_sel(in_sel), .in_bcast(in_bcast), .ch_en(ch_en),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .drop_cnt(drop_cnt), .busy(busy)
    );

    stream_demux #(.WIDTH(8), .N_OUT(3), .SEL_W(2), .CNT_W(2)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .in_sel(b_in_sel), .in_bcast(b_in_bcast), .ch_en(b_ch_en),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .drop_cnt(b_drop_cnt), .busy(b_busy)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: each lane owns a queue of words it still has to deliver.
    logic [7:0] q[4][$];
    int         m_drops = 0;
    bit         mon_en = 1'b0;

    function automatic logic [3:0] m_valid();
        logic [3:0] v;
        for (int i = 0; i < 4; i++) v[i] = (q[i].size() != 0);
        return v;
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            logic [3:0] ev;
            logic [3:0] m;
            logic       er;
            ev = m_valid();
            er = ((ev & ~out_ready) == 4'b0);
            chk("out_valid", 32'(out_valid), 32'(ev));
            chk("in_ready", 32'(in_ready), 32'(er));
            chk("busy", 32'(busy), 32'(ev != 4'b0));
            chk("drop_cnt", 32'(drop_cnt), 32'(m_drops));
            for (int i = 0; i < 4; i++) begin
                if (ev[i]) begin
                    chk($sformatf("data_ch%0d", i), 32'(out_data), 32'(q[i][0]));
                    if (out_ready[i]) void'(q[i].pop_front());
                end
            end
            if (in_valid && er) begin
                m = in_bcast ? ch_en : ((4'b0001 << in_sel) & ch_en);
                if (m == 4'b0) begin
                    if (m_drops < 255) m_drops++;
                end else begin
                    for (int i = 0; i < 4; i++) if (m[i]) q[i].push_back(in_data);
                end
            end
        end
    end

    task automatic cyc(input logic v, input logic [7:0] d, input logic [1:0] s,
                       input logic b, input logic [3:0] en, input logic [3:0] rdy);
        in_valid  = v;
        in_data   = d;
        in_sel    = s;
        in_bcast  = b;
        ch_en     = en;
        out_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 4; i++) q[i].delete();
        m_drops = 0;
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 0; in_data = 0; in_sel = 0; in_bcast = 0;
        ch_en = 4'hF; out_ready = 4'h0;
        b_in_valid = 0; b_in_data = 8'h11; b_in_sel = 0; b_in_bcast = 0;
        b_ch_en = 3'b111; b_out_ready = 3'b111;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_drop_cnt", 32'(drop_cnt), 0);
        chk("rst_out_data", 32'(out_data), 0);
        chk("rst_busy", 32'(busy), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        mon_en = 1'b1;

        // Unicast stream at full rate
        for (int k = 0; k < 4; k++) begin
            cyc(1, 8'hA0 + 8'(k), 2'(k), 0, 4'hF, 4'hF);
            chk("uni_out_valid", 32'(out_valid), 32'(4'b0001 << k));
            chk("uni_data", 32'(out_data), 32'(8'hA0 + 8'(k)));
        end
        cyc(0, 0, 0, 0, 4'hF, 4'hF);

        // Broadcast with staggered readies
        cyc(1, 8'h5A, 0, 1, 4'b1011, 4'b0000);
        chk("bc_pend", 32'(out_valid), 32'(4'b1011));
        cyc(0, 0, 0, 0, 4'b1011, 4'b0001);
        cyc(0, 0, 0, 0, 4'b1011, 4'b0011);
        cyc(0, 0, 0, 0, 4'b1011, 4'b1011);
        chk("bc_busy_after", 32'(busy), 0);

        // Unroutable word is dropped
        cyc(1, 8'h77, 2, 0, 4'b1011, 4'hF);
        chk("drop_cnt1", 32'(drop_cnt), 1);
        chk("drop_out_valid", 32'(out_valid), 0);
        chk("drop_out_data", 32'(out_data), 32'(8'h5A));
        cyc(0, 0, 0, 0, 4'hF, 4'hF);

        // Three-lane instance: out-of-range select and saturation at 3
        b_in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            b_in_sel = (k == 0) ? 2'd3 : 2'd0;
            b_ch_en  = (k == 0) ? 3'b111 : 3'b000;
            @(posedge clk);
            #1;
            chk("sat_cnt", 32'(b_drop_cnt), (k + 1 > 3) ? 3 : k + 1);
            chk("sat_out_valid", 32'(b_out_valid), 0);
        end
        b_in_valid = 1'b0;

        // Enable cleared during HOLD does not cancel delivery
        cyc(1, 8'hC3, 2, 0, 4'hF, 4'h0);
        cyc(0, 0, 0, 0, 4'b1011, 4'h0);
        chk("en_hold_valid", 32'(out_valid), 32'(4'b0100));
        cyc(0, 0, 0, 0, 4'b1011, 4'hF);
        chk("en_delivered", 32'(out_valid), 0);

        // Asynchronous reset in the middle of HOLD
        cyc(1, 8'h3C, 2, 0, 4'hF, 4'h0);
        chk("pre_rst_valid", 32'(out_valid), 32'(4'b0100));
        in_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(out_valid), 0);
        chk("async_rst_data", 32'(out_data), 0);
        chk("async_rst_cnt", 32'(drop_cnt), 0);
        model_clear();
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Randomised traffic
        for (int k = 0; k < 2000; k++) begin
            logic [3:0] r;
            r = 4'($urandom) | 4'($urandom);
            cyc(($urandom % 4) != 0, 8'($urandom), 2'($urandom), ($urandom % 5) == 0,
                4'($urandom), r);
        end
        repeat (4) cyc(0, 0, 0, 0, 4'hF, 4'hF);
        chk("final_idle", 32'(busy), 0);

        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
